wb_queue: RTL
=============

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, >= 2).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports in_valid_1 / in_valid_2  in  1  result valid, lane 1 older than lane 2.
REQ-005 SHALL have ports in_addr_1 / in_addr_2  in  5  destination register.
REQ-006 SHALL have ports in_data_1 / in_data_2  in  32  result value.
REQ-007 SHALL have port in_ready  out  1  both lanes may be accepted this cycle.
REQ-008 SHALL have port wb_stall  in  1  hold draining; enqueue unaffected.
REQ-009 SHALL have ports reg_w_en_1 / reg_w_en_2  out  1  register-file write enables.
REQ-010 SHALL have ports reg_w_addr_1 / reg_w_addr_2  out  5  write addresses.
REQ-011 SHALL have ports reg_w_data_1 / reg_w_data_2  out  32  write data.
REQ-012 SHALL have port count  out  $clog2(DEPTH)+1  occupied entries.
REQ-013 SHALL have ports byp_addr  in  5, byp_hit  out  1, byp_data  out  32  pending-value lookup.

Function
REQ-014 SHALL assert in_ready iff DEPTH - count >= 2, using count before this cycle's pop.
REQ-015 SHALL ignore in_valid_* when in_ready = 0; no partial acceptance.
REQ-016 SHALL drop any lane with address 0 at enqueue; it consumes no entry.
REQ-017 SHALL enqueue accepted lanes in order lane 1 then lane 2, compacting when only one is valid.
REQ-018 SHALL, each cycle with wb_stall = 0, pop up to two oldest entries into registered outputs: oldest to port 1, next to port 2.
REQ-019 SHALL, when one entry is popped, drive it on port 1 and hold reg_w_en_2 = 0.
REQ-020 SHALL drive reg_w_en_* high for exactly one cycle per popped entry; with wb_stall = 1 or empty queue, both enables are 0 next cycle.
REQ-021 SHALL give latency 2 edges: an entry enqueued at edge N into an empty queue appears on the write port after edge N+1.
REQ-022 SHALL allow push and pop in the same cycle; count(next) = count + pushed - popped.
REQ-023 SHALL preserve program order for the same address: when both ports carry the same address, port 2 carries the younger value, because the register file gives port 2 priority.
REQ-024 SHALL wrap read and write pointers modulo DEPTH with no bubble.
REQ-025 SHALL never overflow: count <= DEPTH in all cases.

Reset
REQ-026 SHALL, on reset assertion and independent of clk, clear count, both pointers, and reg_w_en_1/2 (and addr/data to 0), and flush all entries.
REQ-027 SHALL drive in_ready = 1 and byp_hit = 0 while reset is held, and discard inputs presented in that time.
REQ-028 SHALL lose in-flight results on reset mid-operation with no partial write emitted.

Configuration
REQ-029 SHALL, with WBQ_BYPASS_EN defined, set byp_hit = 1 and byp_data to the youngest matching value among the queue entries and the output registers, with the youngest match winning; byp_addr = 0 gives hit 0 and data 0.
REQ-030 SHALL, without WBQ_BYPASS_EN, keep the byp_* ports but tie byp_hit and byp_data to 0 and include no lookup logic.

Structure
REQ-031 SHALL place the entry typedef (addr 5, data 32), REG_ADDR_W = 5 and DATA_W = 32 in shared package wbq_pkg.
REQ-032 SHALL implement dual-push/dual-pop storage as sub-module wbq_fifo2; bypass priority search SHALL stay in wb_queue.

Verification
REQ-033 SHALL cover: empty queue, lane 1 (r5, 0x11) and lane 2 (r6, 0x22) at edge 0 -> after edge 1, port 1 = r5/0x11 and port 2 = r6/0x22, both enables set for one cycle.
REQ-034 SHALL cover: lane 1 (r3, 0xA) and lane 2 (r3, 0xB) -> port 1 = r3/0xA and port 2 = r3/0xB; a register-file read of r3 afterwards returns 0xB.
REQ-035 SHALL cover: DEPTH = 4, wb_stall = 1, two dual pushes -> count = 4 and in_ready = 0; a third push is ignored; after releasing stall, four writes over two cycles in order.
REQ-036 SHALL cover: lane 1 with address 0 and lane 2 (r7, 0x77) -> only r7 is queued, count = 1, r7 appears on port 1.
REQ-037 SHALL cover: with WBQ_BYPASS_EN, queue holds r9 = 0x1 then r9 = 0x2 and byp_addr = 9 -> byp_hit = 1 and byp_data = 0x2; without the macro, byp_hit = 0.
REQ-038 SHALL cover: reset asserted mid-cycle with count = 3 -> immediately count = 0 and enables = 0; no write occurs after release.

Source files
------------

// File: rtl/wbq_pkg.sv
// Shared types and widths for the writeback queue.
package wbq_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wbq_entry_t;

    function automatic logic [1:0] lane_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/wbq_fifo2.sv
// Dual-push / dual-pop circular store. Exposes its raw entries and read
// pointer so the parent can run the pending-value search.
module wbq_fifo2
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [1:0]                     push_n,
    input  wbq_entry_t                     push_a,
    input  wbq_entry_t                     push_b,
    input  logic [1:0]                     pop_n,
    output wbq_entry_t                     head_a,
    output wbq_entry_t                     head_b,
    output logic [$clog2(DEPTH):0]         count,
    output wbq_entry_t [DEPTH-1:0]         entries,
    output logic [$clog2(DEPTH)-1:0]       rd_ptr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wbq_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          wr_ptr_nx;
    logic [PW-1:0]          rd_ptr_nx;

    // Power-of-two depth lets pointers wrap by plain overflow.
    assign wr_ptr_nx = wr_ptr + PW'(1);
    assign rd_ptr_nx = rd_ptr + PW'(1);

    assign head_a  = mem[rd_ptr];
    assign head_b  = mem[rd_ptr_nx];
    assign entries = mem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_n != 2'd0) mem[wr_ptr]    <= push_a;
            if (push_n == 2'd2) mem[wr_ptr_nx] <= push_b;
            wr_ptr <= wr_ptr + PW'(push_n);
            rd_ptr <= rd_ptr + PW'(pop_n);
            count  <= count + CW'(push_n) - CW'(pop_n);
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Two-lane writeback queue feeding a dual-write register file.
// Optional pending-value lookup enabled by defining WBQ_BYPASS_EN.
module wb_queue
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid_1,
    input  logic [REG_ADDR_W-1:0]   in_addr_1,
    input  logic [DATA_W-1:0]       in_data_1,
    input  logic                    in_valid_2,
    input  logic [REG_ADDR_W-1:0]   in_addr_2,
    input  logic [DATA_W-1:0]       in_data_2,
    output logic                    in_ready,
    input  logic                    wb_stall,
    output logic                    reg_w_en_1,
    output logic [REG_ADDR_W-1:0]   reg_w_addr_1,
    output logic [DATA_W-1:0]       reg_w_data_1,
    output logic                    reg_w_en_2,
    output logic [REG_ADDR_W-1:0]   reg_w_addr_2,
    output logic [DATA_W-1:0]       reg_w_data_2,
    output logic [$clog2(DEPTH):0]  count,
    input  logic [REG_ADDR_W-1:0]   byp_addr,
    output logic                    byp_hit,
    output logic [DATA_W-1:0]       byp_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic                   take_1;
    logic                   take_2;
    logic [1:0]             push_n;
    logic [1:0]             pop_n;
    wbq_entry_t             lane_1;
    wbq_entry_t             lane_2;
    wbq_entry_t             push_a;
    wbq_entry_t             head_a;
    wbq_entry_t             head_b;
    wbq_entry_t [DEPTH-1:0] entries;
    logic [PW-1:0]          rd_ptr;

    // Admission is all-or-nothing, so room for two is required regardless of lane usage.
    assign in_ready = (count <= CW'(DEPTH - 2));

    assign take_1 = in_ready && in_valid_1 && (in_addr_1 != '0);
    assign take_2 = in_ready && in_valid_2 && (in_addr_2 != '0);
    assign push_n = lane_count(take_1, take_2);

    assign lane_1 = '{addr: in_addr_1, data: in_data_1};
    assign lane_2 = '{addr: in_addr_2, data: in_data_2};
    assign push_a = take_1 ? lane_1 : lane_2;

    always_comb begin
        pop_n = 2'd0;
        if (!wb_stall) pop_n = (count >= CW'(2)) ? 2'd2 : count[1:0];
    end

    wbq_fifo2 #(.DEPTH(DEPTH)) fifo (
        .clk     (clk),
        .reset   (reset),
        .push_n  (push_n),
        .push_a  (push_a),
        .push_b  (lane_2),
        .pop_n   (pop_n),
        .head_a  (head_a),
        .head_b  (head_b),
        .count   (count),
        .entries (entries),
        .rd_ptr  (rd_ptr)
    );

    // Older entry always lands on port 1; the register file favours port 2 on collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_w_en_1   <= 1'b0;
            reg_w_addr_1 <= '0;
            reg_w_data_1 <= '0;
            reg_w_en_2   <= 1'b0;
            reg_w_addr_2 <= '0;
            reg_w_data_2 <= '0;
        end else begin
            reg_w_en_1 <= (pop_n != 2'd0);
            reg_w_en_2 <= (pop_n == 2'd2);
            if (pop_n != 2'd0) begin
                reg_w_addr_1 <= head_a.addr;
                reg_w_data_1 <= head_a.data;
            end
            if (pop_n == 2'd2) begin
                reg_w_addr_2 <= head_b.addr;
                reg_w_data_2 <= head_b.data;
            end
        end
    end

`ifdef WBQ_BYPASS_EN
    logic [PW-1:0] idx;

    // Scan oldest to youngest so later matches overwrite earlier ones.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        idx      = rd_ptr;
        if (byp_addr != '0) begin
            if (reg_w_en_1 && reg_w_addr_1 == byp_addr) begin
                byp_hit  = 1'b1;
                byp_data = reg_w_data_1;
            end
            if (reg_w_en_2 && reg_w_addr_2 == byp_addr) begin
                byp_hit  = 1'b1;
                byp_data = reg_w_data_2;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + PW'(i);
                if (CW'(i) < count && entries[idx].addr == byp_addr) begin
                    byp_hit  = 1'b1;
                    byp_data = entries[idx].data;
                end
            end
        end
    end
`else
    logic unused_lookup;

    assign unused_lookup = ^{byp_addr, entries, rd_ptr};
    assign byp_hit       = 1'b0;
    assign byp_data      = '0;
`endif

endmodule
